// File: rtl/keypad_pkg.sv
// Shared types and key map for the keypad entry path.
package keypad_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DEBOUNCE,
        HELD,
        RELEASE
    } key_state_e;

    typedef enum logic [1:0] {
        NONE,
        SINGLE,
        MULTI
    } frame_res_e;

    // Indexed by row*4 + col; entry 0 is the rightmost element.
    //   r0: 1 2 3 A   r1: 4 5 6 B   r2: 7 8 9 C   r3: E(*) 0 F(#) D
    localparam logic [15:0][3:0] KEY_MAP = {
        4'hD, 4'hF, 4'h0, 4'hE,
        4'hC, 4'h9, 4'h8, 4'h7,
        4'hB, 4'h6, 4'h5, 4'h4,
        4'hA, 4'h3, 4'h2, 4'h1
    };

endpackage

// File: rtl/keypad_scanner.sv
// Column scanner: drives one column at a time, synchronizes ROWS and
// emits one classified result per full four-column frame.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] rows,
    output logic [3:0] cols,
    output logic       frame_stb,
    output logic [1:0] frame_res,
    output logic [3:0] frame_code
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [DW-1:0]   div_cnt;
    logic [1:0]      col_idx;
    logic            dwell_end;
    logic [3:0]      rows_s1, rows_s2;
    // Dwell-end / column tags delayed to line up with the synchronizer output,
    // so the sample always belongs to the column that produced it.
    logic [1:0]      end_pipe;
    logic [1:0][1:0] col_pipe;
    logic            samp;
    logic [1:0]      samp_col;
    logic [15:0]     press_acc, merged;
    logic            any_hit, multi_hit;
    logic [3:0]      hit_idx;

    assign dwell_end = (div_cnt == DW'(SCAN_DIV - 1));
    assign cols      = ~(4'b0001 << col_idx);
    assign samp      = end_pipe[1];
    assign samp_col  = col_pipe[1];

    // Column dwell counter and column rotation 0..3.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            col_idx <= 2'd0;
        end else if (dwell_end) begin
            div_cnt <= '0;
            col_idx <= col_idx + 2'd1;
        end else begin
            div_cnt <= div_cnt + DW'(1);
        end
    end

    // Two-flop ROWS synchronizer plus the matching tag delay line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rows_s1  <= 4'hF;
            rows_s2  <= 4'hF;
            end_pipe <= '0;
            col_pipe <= '0;
        end else begin
            rows_s1  <= rows;
            rows_s2  <= rows_s1;
            end_pipe <= {end_pipe[0], dwell_end};
            col_pipe <= {col_pipe[0], col_idx};
        end
    end

    // Current frame bits with the column being sampled merged in.
    always_comb begin
        merged = press_acc;
        for (int r = 0; r < 4; r++)
            merged[4*r + int'(samp_col)] = ~rows_s2[r];
    end

    // Latch the sampled column into the frame press map.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            press_acc <= '0;
        else if (samp)
            press_acc <= merged;
    end

    // Classify the completed frame: none, exactly one, or several keys.
    always_comb begin
        any_hit   = 1'b0;
        multi_hit = 1'b0;
        hit_idx   = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (merged[i]) begin
                if (any_hit)
                    multi_hit = 1'b1;
                any_hit = 1'b1;
                hit_idx = 4'(i);
            end
        end
    end

    assign frame_stb  = samp && (samp_col == 2'd3);
    assign frame_res  = !any_hit ? NONE : (multi_hit ? MULTI : SINGLE);
    assign frame_code = KEY_MAP[hit_idx];

endmodule

// File: rtl/keypad_entry.sv
// Keypad entry: debounces scanned key frames and shifts accepted digits
// into a 4-digit register presented as hex or binary-from-decimal.
module keypad_entry
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 20
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [3:0]  ROWS,
    input  logic        MODE,
    input  logic        CLR,
    output logic [3:0]  COLS,
    output logic [15:0] DATA_OUT,
    output logic        KEY_VALID,
    output logic [3:0]  KEY_CODE,
    output logic        KEY_HELD
);

    localparam int CW = (DEBOUNCE_SCANS > 1) ? $clog2(DEBOUNCE_SCANS + 1) : 1;

    logic          frame_stb;
    logic [1:0]    frame_res_raw;
    frame_res_e    res;
    logic [3:0]    frame_code;
    key_state_e    state;
    logic [3:0]    cand;
    logic [CW-1:0] cnt;
    logic          accept;
    logic          mode_r, mode_d;
    logic [15:0]   nib;
    logic [15:0]   dec_val;

    keypad_scanner #(.SCAN_DIV(SCAN_DIV)) u_scan (
        .clk        (CLK),
        .rst_n      (RST_N),
        .rows       (ROWS),
        .cols       (COLS),
        .frame_stb  (frame_stb),
        .frame_res  (frame_res_raw),
        .frame_code (frame_code)
    );

    assign res = frame_res_e'(frame_res_raw);

    // A press is accepted on the frame that completes the debounce count.
    assign accept = frame_stb && (res == SINGLE) &&
                    (((state == IDLE) && (DEBOUNCE_SCANS == 1)) ||
                     ((state == DEBOUNCE) && (frame_code == cand) &&
                      (cnt == CW'(DEBOUNCE_SCANS - 1))));

    // Debounce FSM, stepped once per frame result; outputs registered.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= IDLE;
            cand      <= 4'd0;
            cnt       <= '0;
            KEY_VALID <= 1'b0;
            KEY_CODE  <= 4'd0;
            KEY_HELD  <= 1'b0;
        end else begin
            KEY_VALID <= accept;
            if (accept)
                KEY_CODE <= frame_code;
            if (frame_stb) begin
                case (state)
                    IDLE: if (res == SINGLE) begin
                        cand <= frame_code;
                        cnt  <= CW'(1);
                        if (accept) begin
                            state    <= HELD;
                            KEY_HELD <= 1'b1;
                        end else begin
                            state <= DEBOUNCE;
                        end
                    end
                    DEBOUNCE: if ((res == SINGLE) && (frame_code == cand)) begin
                        if (accept) begin
                            state    <= HELD;
                            KEY_HELD <= 1'b1;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end else begin
                        state <= IDLE;
                    end
                    // No rollover: other keys are ignored until a clean release.
                    HELD: if (res == NONE) begin
                        cnt <= CW'(1);
                        if (DEBOUNCE_SCANS == 1) begin
                            state    <= IDLE;
                            KEY_HELD <= 1'b0;
                        end else begin
                            state <= RELEASE;
                        end
                    end
                    RELEASE: if (res == NONE) begin
                        if (cnt == CW'(DEBOUNCE_SCANS - 1)) begin
                            state    <= IDLE;
                            KEY_HELD <= 1'b0;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end else begin
                        state <= HELD;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Digit register: clear wins over accumulate; a mode change also clears.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            mode_r <= 1'b0;
            mode_d <= 1'b0;
            nib    <= '0;
        end else begin
            mode_r <= MODE;
            mode_d <= mode_r;
            if (CLR || (mode_r != mode_d))
                nib <= '0;
            else if (accept && (!mode_r || (frame_code <= 4'd9)))
                nib <= {nib[11:0], frame_code};
        end
    end

    // Decimal digits are always 0..9, so the weighted sum fits 0..9999.
    assign dec_val = 16'(nib[15:12]) * 16'd1000 + 16'(nib[11:8]) * 16'd100 +
                     16'(nib[7:4]) * 16'd10 + 16'(nib[3:0]);
    assign DATA_OUT = mode_r ? dec_val : nib;

endmodule
